// File: rtl/seq_div_32_pkg.sv
// -----------------------------------------------------------------------------
// seq_div_32_pkg
//   Shared types and constants for the sequential 32-bit restoring divider.
//   Imported by the divider interface, the trial-subtract adder and the
//   divider top.
//
//   Contents
//     DATA_WIDTH   data path width (32)
//     ITER_W       iteration counter width; wide enough to hold 32
//     LAST_ITER    counter value of the final quotient-bit step
//     div_state_t  FSM state encoding (IDLE / CALC / DONE)
// -----------------------------------------------------------------------------
package seq_div_32_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ITER_W     = 6;

    // The counter starts at 0 on accept, so the 32nd step runs with count 31.
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_DONE = 2'b10
    } div_state_t;

    // Result pattern reported for a zero divisor: all-ones quotient.
    localparam logic [DATA_WIDTH-1:0] DBZ_QUOTIENT = '1;

endpackage : seq_div_32_pkg

// File: rtl/seq_div_32_if.sv
// -----------------------------------------------------------------------------
// seq_div_32_if
//   START/DONE handshake and data bundle between the ALU control (master)
//   and the sequential divider (slave).
//
//   Signals
//     start        master->slave  request, honoured only while the divider idles
//     dividend     master->slave  numerator, captured on an accepted start
//     divisor      master->slave  denominator, captured on an accepted start
//     busy         slave->master  high while computing and during the done cycle
//     done         slave->master  one-cycle pulse, results valid
//     quotient     slave->master  held until the next accepted start
//     remainder    slave->master  held until the next accepted start
//     div_by_zero  slave->master  zero-divisor flag of the last operation
// -----------------------------------------------------------------------------
interface seq_div_32_if;
    import seq_div_32_pkg::*;

    logic                  start;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] quotient;
    logic [DATA_WIDTH-1:0] remainder;
    logic                  div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );

endinterface : seq_div_32_if

// File: rtl/seq_div_32_add_sub.sv
// -----------------------------------------------------------------------------
// seq_div_32_add_sub
//   32-bit ripple-carry adder/subtractor (the RC_ADD_SUB_32 block).
//   sub=0: y = a + b;  sub=1: y = a - b computed as a + ~b + 1.
//   In subtract mode co=1 means no borrow (a >= b, unsigned).
//
//   Ports
//     a    in   32  first operand
//     b    in   32  second operand
//     sub  in   1   1 = subtract, 0 = add
//     y    out  32  sum / difference, mod 2^32
//     co   out  1   carry out of bit 31
// -----------------------------------------------------------------------------
module seq_div_32_add_sub
    import seq_div_32_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  sub,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  co
);

    // Carry is a block-local variable walked LSB to MSB, which keeps the
    // ripple chain a plain sequence of full adders without a feedback vector.
    always_comb begin
        logic c;
        logic bb;
        // NOTE: every output of a combinational block gets a value before any
        // branch or loop, so no path can leave it holding state (no latch).
        y = '0;
        c = sub;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            bb   = b[i] ^ sub;
            y[i] = a[i] ^ bb ^ c;
            c    = (a[i] & bb) | (c & (a[i] ^ bb));
        end
        co = c;
    end

endmodule : seq_div_32_add_sub

// File: rtl/seq_div_32.sv
// -----------------------------------------------------------------------------
// seq_div_32
//   Multi-cycle unsigned 32-bit restoring divider for the ALU DIV/REM ops.
//   One quotient bit per cycle: the partial remainder is shifted left by one,
//   the next dividend bit shifted in, and the divisor trial-subtracted by the
//   ripple-carry adder/subtractor. A zero divisor skips the iteration and
//   reports an all-ones quotient with the dividend as remainder.
//
//   Latency: start accepted at edge N -> done high in the cycle after edge
//   N+32 (32 iterations); zero divisor -> done high in the cycle after edge N.
//   A new start is honoured in the cycle after done.
//
//   Ports
//     clk   in   1   system clock, rising edge
//     rst   in   1   asynchronous, active-low reset
//     bus   slave    seq_div_32_if handshake and data (see interface header)
// -----------------------------------------------------------------------------
module seq_div_32
    import seq_div_32_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    seq_div_32_if.slave   bus
);

    // FSM and working registers
    div_state_t            state;
    logic [DATA_WIDTH-1:0] rem_q;    // partial remainder R
    logic [DATA_WIDTH-1:0] quo_q;    // dividend shifting out / quotient shifting in (Q)
    logic [DATA_WIDTH-1:0] dvs_q;    // captured divisor D
    logic [ITER_W-1:0]     count;

    // Registered outputs
    logic                  busy_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] quotient_q;
    logic [DATA_WIDTH-1:0] remainder_q;
    logic                  dbz_q;

    // One iteration step
    logic [DATA_WIDTH-1:0] shifted;   // S = {R[30:0], Q[31]}
    logic [DATA_WIDTH-1:0] trial;     // T = S - D (mod 2^32)
    logic                  no_borrow; // adder carry out
    logic                  accept_bit;
    logic [DATA_WIDTH-1:0] rem_next;
    logic [DATA_WIDTH-1:0] quo_next;

    assign shifted = {rem_q[DATA_WIDTH-2:0], quo_q[DATA_WIDTH-1]};

    seq_div_32_add_sub u_add_sub (
        .a   (shifted),
        .b   (dvs_q),
        .sub (1'b1),
        .y   (trial),
        .co  (no_borrow)
    );

    // R[31] is the 33rd bit of the shifted remainder: when set, the true
    // shifted value is at least 2^32 and therefore exceeds any divisor, so the
    // subtraction always succeeds and the mod-2^32 difference is exact.
    assign accept_bit = rem_q[DATA_WIDTH-1] | no_borrow;
    assign rem_next   = accept_bit ? trial : shifted;
    assign quo_next   = {quo_q[DATA_WIDTH-2:0], accept_bit};

    // NOTE: the reset branch is asynchronous (in the sensitivity list) and
    // clears every register here, including the working R/Q/D/count, so an
    // aborted operation leaves nothing behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= DIV_IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            count       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples the pre-edge values regardless of statement order.
            case (state)
                DIV_IDLE: begin
                    if (bus.start) begin
                        rem_q  <= '0;
                        quo_q  <= bus.dividend;
                        dvs_q  <= bus.divisor;
                        count  <= '0;
                        busy_q <= 1'b1;
                        dbz_q  <= (bus.divisor == '0);
                        if (bus.divisor == '0) begin
                            // Nothing to iterate: results are known now.
                            quotient_q  <= DBZ_QUOTIENT;
                            remainder_q <= bus.dividend;
                            done_q      <= 1'b1;
                            state       <= DIV_DONE;
                        end else begin
                            state       <= DIV_CALC;
                        end
                    end
                end

                DIV_CALC: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    count <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        // Results are taken from the final step directly so
                        // they are valid in the same cycle done goes high.
                        quotient_q  <= quo_next;
                        remainder_q <= rem_next;
                        done_q      <= 1'b1;
                        state       <= DIV_DONE;
                    end
                end

                DIV_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= DIV_IDLE;
                end

                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= DIV_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule : seq_div_32

// File: tb/tb_seq_div_32.sv
// -----------------------------------------------------------------------------
// tb_seq_div_32
//   Directed self-checking bench for seq_div_32. Inputs are driven on the
//   falling edge and outputs sampled on the falling edge. Latency is counted
//   as falling edges after the accepting rising edge: 33 for a normal
//   divide, 1 for a zero divisor.
// -----------------------------------------------------------------------------
module tb_seq_div_32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_div_32_if bus ();

    seq_div_32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present operands at a falling edge and let the next rising edge accept.
    task automatic apply_start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
    endtask

    // Bounded wait for done; lat = 0 when it never arrives.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input logic exp_z, input int exp_lat);
        int lat;
        apply_start(a, b);
        wait_done(lat);
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".quotient"}, bus.quotient, exp_q);
        check({tag, ".remainder"}, bus.remainder, exp_r);
        check({tag, ".dbz"}, {31'd0, bus.div_by_zero}, {31'd0, exp_z});
        check({tag, ".busy_at_done"}, {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        check({tag, ".done_pulse"}, {31'd0, bus.done}, 32'd0);
        check({tag, ".busy_after"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        bit saw_done;
        logic [31:0] a, b, eq, er;

        // ---- reset state
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #12;
        check("reset.busy", {31'd0, bus.busy}, 32'd0);
        check("reset.done", {31'd0, bus.done}, 32'd0);
        check("reset.quotient", bus.quotient, 32'd0);
        check("reset.remainder", bus.remainder, 32'd0);
        check("reset.dbz", {31'd0, bus.div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // ---- basic and R[31] path
        run_op("t1_100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        run_op("t2_ffff_8001", 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, 33);
        run_op("t2_8000_ffff", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33);

        // ---- divide by zero
        run_op("t3_5_0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);

        // ---- start held during busy with other operands
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd10;
        @(posedge clk);
        #1;
        bus.dividend = 32'd7;
        bus.divisor  = 32'd3;
        check("t4.dbz_cleared_on_accept", {31'd0, bus.div_by_zero}, 32'd0);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 16) begin
                check("t4.quotient_stable", bus.quotient, 32'hFFFF_FFFF);
                check("t4.remainder_stable", bus.remainder, 32'd5);
                check("t4.busy_mid", {31'd0, bus.busy}, 32'd1);
            end
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("t4_1000_10.latency", 32'(lat), 32'd33);
        check("t4_1000_10.quotient", bus.quotient, 32'd100);
        check("t4_1000_10.remainder", bus.remainder, 32'd0);
        @(posedge clk);
        #1;
        check("t4.idle_after_done", {31'd0, bus.busy}, 32'd0);
        check("t4.result_held", bus.quotient, 32'd100);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("t4.second_accepted", {31'd0, bus.busy}, 32'd1);
        wait_done(lat);
        check("t4_7_3.latency", 32'(lat), 32'd33);
        check("t4_7_3.quotient", bus.quotient, 32'd2);
        check("t4_7_3.remainder", bus.remainder, 32'd1);

        // ---- reset mid-operation
        @(negedge clk);
        apply_start(32'hDEAD_BEEF, 32'd3);
        repeat (15) @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5.rst_busy", {31'd0, bus.busy}, 32'd0);
        check("t5.rst_done", {31'd0, bus.done}, 32'd0);
        check("t5.rst_quotient", bus.quotient, 32'd0);
        check("t5.rst_remainder", bus.remainder, 32'd0);
        check("t5.rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
        end
        check("t5.no_done_after_abort", {31'd0, saw_done}, 32'd0);
        run_op("t5_9_4", 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 33);

        // ---- boundaries
        run_op("t6_ffff_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
        run_op("t6_0_1234", 32'd0, 32'h1234_5678, 32'd0, 32'd0, 1'b0, 33);

        // ---- random vectors against the / and % operators
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 4 == 1) b = b >> $urandom_range(31, 0);
            if (i % 50 == 7) b = 32'd0;
            if (b == 32'd0) begin
                eq = 32'hFFFF_FFFF;
                er = a;
            end else begin
                eq = a / b;
                er = a % b;
            end
            run_op("rand", a, b, eq, er, (b == 32'd0), (b == 32'd0) ? 1 : 33);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_seq_div_32
